// File: rtl/stack_op_sequencer_if.sv
// stack_op_sequencer_if: control-unit, stack and ALU signals of the stack sequencer
interface stack_op_sequencer_if #(
    parameter int W  = 16,
    parameter int CW = 5
);
    logic          start;
    logic [3:0]    opcode;
    logic [W-1:0]  imm;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    logic [W-1:0]  result;
    logic [CW-1:0] depth;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_controle_pilha;
    logic [W-1:0]  stk_din_uc;
    logic [W-1:0]  stk_dout;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2*W-1:0] alu_res;

    modport master (
        output start, opcode, imm, stk_dout, alu_res,
        input  busy, done, err_code, result, depth, stk_push, stk_pop,
               stk_controle_pilha, stk_din_uc, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, opcode, imm, stk_dout, alu_res,
        output busy, done, err_code, result, depth, stk_push, stk_pop,
               stk_controle_pilha, stk_din_uc, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: control FSM sequencing pops, ALU hand-off and pushes on the operand stack
module stack_op_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input logic                clk,
    input logic                rst,
    stack_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, POP1, POP2, CAP, PUSH1, PUSH2, DONE} state_t;
    state_t        state;
    logic [3:0]    op;
    logic          busy, done, push, pop, ctl;
    logic [1:0]    err;
    logic [W-1:0]  result, din_uc, a, b;
    logic [CW-1:0] depth;
    logic [2:0]    alu_op;
    logic [1:0]    chk;
    logic          is_bin;
    logic          unused;
    assign unused = ^bus.alu_res[2*W-1:W];
    // Legality check of the offered instruction against the current depth
    always_comb begin
        is_bin = bus.opcode >= 4'd4 && bus.opcode <= 4'd8;
        chk = bus.opcode > 4'd8 ? 2'd3 :
              bus.opcode == 4'd1 && depth == CW'(DEPTH) ? 2'd2 :
              (bus.opcode == 4'd2 || bus.opcode == 4'd3) && depth == '0 ? 2'd1 :
              bus.opcode == 4'd3 && depth == CW'(DEPTH) ? 2'd2 :
              is_bin && depth < CW'(2) ? 2'd1 : 2'd0;
    end
    // Instruction FSM; every output is a register so the stack sees clean strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            push <= 1'b0;
            pop <= 1'b0;
            ctl <= 1'b0;
            err <= '0;
            result <= '0;
            din_uc <= '0;
            a <= '0;
            b <= '0;
            depth <= '0;
            alu_op <= '0;
        end else begin
            push <= 1'b0;
            pop <= 1'b0;
            ctl <= 1'b0;
            done <= 1'b0;
            depth <= depth + CW'(push) - CW'(pop);
            case (state)
                IDLE: if (bus.start) begin
                    op <= bus.opcode;
                    busy <= 1'b1;
                    err <= chk;
                    if (chk != 2'd0 || bus.opcode == 4'd0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else if (bus.opcode == 4'd1) begin
                        state <= PUSH1;
                        push <= 1'b1;
                        din_uc <= bus.imm;
                    end else begin
                        state <= POP1;
                        pop <= 1'b1;
                        alu_op <= is_bin ? 3'(bus.opcode - 4'd4) : alu_op;
                    end
                end
                POP1: begin
                    state <= op >= 4'd4 ? POP2 : CAP;
                    pop <= op >= 4'd4;
                end
                POP2: begin
                    b <= bus.stk_dout;
                    state <= CAP;
                end
                CAP: begin
                    if (op == 4'd2) begin
                        result <= bus.stk_dout;
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        din_uc <= op == 4'd3 ? bus.stk_dout : din_uc;
                        a <= op == 4'd3 ? a : bus.stk_dout;
                        ctl <= op != 4'd3;
                        push <= 1'b1;
                        state <= PUSH1;
                    end
                end
                PUSH1: begin
                    result <= op >= 4'd4 ? bus.alu_res[W-1:0] : result;
                    push <= op == 4'd3;
                    state <= op == 4'd3 ? PUSH2 : DONE;
                    done <= op != 4'd3;
                end
                PUSH2: begin
                    state <= DONE;
                    done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err_code = err;
    assign bus.result = result;
    assign bus.depth = depth;
    assign bus.stk_push = push;
    assign bus.stk_pop = pop;
    assign bus.stk_controle_pilha = ctl;
    assign bus.stk_din_uc = din_uc;
    assign bus.alu_op = alu_op;
    assign bus.alu_a = a;
    assign bus.alu_b = b;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: scoreboard bench with a behavioural stack and ALU around the sequencer
module tb_stack_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    stack_op_sequencer_if #(.W(16), .CW(5)) bus();

    stack_op_sequencer #(.W(16), .DEPTH(16), .CW(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural 16-entry stack: dout updates on the edge that pops
    logic [15:0] mem [16];
    int sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= 0;
            bus.stk_dout <= '0;
        end else if (bus.stk_push && sp < 16) begin
            mem[sp] <= bus.stk_controle_pilha ? bus.alu_res[15:0] : bus.stk_din_uc;
            sp <= sp + 1;
        end else if (bus.stk_pop && sp > 0) begin
            bus.stk_dout <= mem[sp-1];
            sp <= sp - 1;
        end
    end

    // Behavioural ALU
    always_comb begin
        case (bus.alu_op)
            3'd0: bus.alu_res = 32'(bus.alu_a) + 32'(bus.alu_b);
            3'd1: bus.alu_res = 32'(bus.alu_a) - 32'(bus.alu_b);
            3'd2: bus.alu_res = 32'(bus.alu_a) * 32'(bus.alu_b);
            3'd3: bus.alu_res = 32'(bus.alu_a & bus.alu_b);
            3'd4: bus.alu_res = 32'(bus.alu_a | bus.alu_b);
            default: bus.alu_res = '0;
        endcase
    end

    typedef struct {
        int          lat;
        logic [1:0]  err;
        logic [15:0] res;
        logic [4:0]  dep;
        int          npush;
        int          npop;
        int          nctl;
    } exp_t;

    exp_t sbq[$];
    logic [15:0] ref_stk[$];
    logic [15:0] last_res = '0;

    task automatic predict(input logic [3:0] opc, input logic [15:0] v);
        exp_t e;
        logic [15:0] a, b, r;
        logic [31:0] p;
        e.err = 2'd0; e.lat = 1; e.npush = 0; e.npop = 0; e.nctl = 0;
        if (opc > 4'd8) e.err = 2'd3;
        else if (opc == 4'd1) begin
            if (ref_stk.size() == 16) e.err = 2'd2;
            else begin ref_stk.push_back(v); e.lat = 2; e.npush = 1; end
        end else if (opc == 4'd2) begin
            if (ref_stk.size() == 0) e.err = 2'd1;
            else begin last_res = ref_stk.pop_back(); e.lat = 3; e.npop = 1; end
        end else if (opc == 4'd3) begin
            if (ref_stk.size() == 0) e.err = 2'd1;
            else if (ref_stk.size() == 16) e.err = 2'd2;
            else begin ref_stk.push_back(ref_stk[$]); e.lat = 5; e.npop = 1; e.npush = 2; end
        end else if (opc >= 4'd4) begin
            if (ref_stk.size() < 2) e.err = 2'd1;
            else begin
                b = ref_stk.pop_back();
                a = ref_stk.pop_back();
                p = 32'(a) * 32'(b);
                case (opc)
                    4'd4: r = a + b;
                    4'd5: r = a - b;
                    4'd6: r = p[15:0];
                    4'd7: r = a & b;
                    default: r = a | b;
                endcase
                ref_stk.push_back(r);
                last_res = r;
                e.lat = 5; e.npop = 2; e.npush = 1; e.nctl = 1;
            end
        end
        e.res = last_res;
        e.dep = 5'(ref_stk.size());
        sbq.push_back(e);
    endtask

    task automatic do_op(input logic [3:0] opc, input logic [15:0] v, input bit hold);
        exp_t e;
        int cyc, npush, npop, nctl;
        string nm;
        nm = $sformatf("op%0d", opc);
        predict(opc, v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.opcode = opc;
        bus.imm = v;
        @(negedge clk);
        bus.start = hold;
        cyc = 1; npush = 0; npop = 0; nctl = 0;
        while (!bus.done && cyc < 20) begin
            npush += int'(bus.stk_push);
            npop += int'(bus.stk_pop);
            nctl += int'(bus.stk_controle_pilha);
            if (bus.stk_push && bus.stk_pop) begin
                tests++; fails++;
                $display("FAIL %s push_and_pop: both strobes high at cycle %0d", nm, cyc);
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e = sbq.pop_front();
        tests++; if (cyc !== e.lat) begin fails++; $display("FAIL %s latency: got %0d exp %0d", nm, cyc, e.lat); end
        tests++; if (bus.err_code !== e.err) begin fails++; $display("FAIL %s err_code: got %0d exp %0d", nm, bus.err_code, e.err); end
        tests++; if (bus.result !== e.res) begin fails++; $display("FAIL %s result: got %h exp %h", nm, bus.result, e.res); end
        tests++; if (bus.depth !== e.dep) begin fails++; $display("FAIL %s depth: got %0d exp %0d", nm, bus.depth, e.dep); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s busy_at_done: got %b exp 1", nm, bus.busy); end
        tests++; if (npush !== e.npush) begin fails++; $display("FAIL %s push_cycles: got %0d exp %0d", nm, npush, e.npush); end
        tests++; if (npop !== e.npop) begin fails++; $display("FAIL %s pop_cycles: got %0d exp %0d", nm, npop, e.npop); end
        tests++; if (nctl !== e.nctl) begin fails++; $display("FAIL %s alu_source_cycles: got %0d exp %0d", nm, nctl, e.nctl); end
    endtask

    task automatic check_zero(input string nm);
        logic [91:0] v;
        v = {bus.busy, bus.done, bus.err_code, bus.result, bus.depth, bus.stk_push, bus.stk_pop,
             bus.stk_controle_pilha, bus.stk_din_uc, bus.alu_op, bus.alu_a, bus.alu_b};
        tests++;
        if (v !== '0) begin fails++; $display("FAIL %s outputs: got %h exp 0", nm, v); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_add_pop;
        do_op(4'd1, 16'd5, 1'b0);
        do_op(4'd1, 16'd3, 1'b0);
        do_op(4'd4, 16'd0, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_sub_mul_logic;
        do_op(4'd1, 16'd10, 1'b0);
        do_op(4'd1, 16'd3, 1'b0);
        do_op(4'd5, 16'd0, 1'b0);
        do_op(4'd1, 16'h0100, 1'b0);
        do_op(4'd6, 16'd0, 1'b0);
        do_op(4'd1, 16'h0F0F, 1'b0);
        do_op(4'd7, 16'd0, 1'b0);
        do_op(4'd1, 16'h1230, 1'b0);
        do_op(4'd8, 16'd0, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_underflow;
        do_op(4'd2, 16'd0, 1'b0);
        do_op(4'd3, 16'd0, 1'b0);
        do_op(4'd1, 16'd7, 1'b0);
        do_op(4'd4, 16'd0, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) do_op(4'd1, 16'(i), 1'b0);
        do_op(4'd1, 16'hBEEF, 1'b0);
        do_op(4'd3, 16'd0, 1'b0);
        for (int i = 0; i < 16; i++) do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_dup_illegal;
        do_op(4'd1, 16'hABCD, 1'b0);
        do_op(4'd3, 16'd0, 1'b0);
        do_op(4'd9, 16'd0, 1'b0);
        do_op(4'd15, 16'd0, 1'b0);
        do_op(4'd0, 16'd0, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_op(4'd1, 16'd21, 1'b1);
        do_op(4'd1, 16'd4, 1'b1);
        do_op(4'd5, 16'd0, 1'b1);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    task automatic test_async_reset;
        do_op(4'd1, 16'd1, 1'b0);
        do_op(4'd1, 16'd2, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.opcode = 4'd4;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero("async_reset");
        tests++;
        if (sp !== 0) begin fails++; $display("FAIL async_reset stack_index: got %0d exp 0", sp); end
        ref_stk.delete();
        last_res = '0;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd1, 16'h00C4, 1'b0);
        do_op(4'd2, 16'd0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.imm = '0;
        test_reset;
        test_add_pop;
        test_sub_mul_logic;
        test_underflow;
        test_overflow;
        test_dup_illegal;
        test_back_to_back;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
